// File: rtl/float_div.sv
// float_div: sequential IEEE-754 binary32 divider (z = a / b).
// Restoring radix-2 quotient, one bit per cycle, round to nearest even,
// denormal operands and results supported, valid/ready on both sides.
module float_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic [3:0]  flags
);

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_NORM, S_DIVIDE,
    S_POSTNORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]       r_a, r_b;
  logic              r_sign;
  logic signed [9:0] r_ea, r_eb, r_ze;
  logic [23:0]       r_am, r_bm;
  logic [24:0]       r_rem;
  logic [26:0]       r_q;
  logic [4:0]        r_cnt;
  logic [23:0]       r_mant;
  logic              r_g, r_r, r_s;
  logic              r_pn_first;
  logic              r_special;
  logic [31:0]       r_z;
  logic [3:0]        r_flags;
  logic              r_out_valid;
  logic              r_in_ready;

  // Operand classification from the captured raw words
  logic [7:0] w_a_exp, w_b_exp;
  logic       w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_a_exp  = r_a[30:23];
  assign w_b_exp  = r_b[30:23];
  assign w_a_nan  = (w_a_exp == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (w_b_exp == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_inf  = (w_a_exp == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (w_b_exp == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_zero = (r_a[30:0] == 31'd0);
  assign w_b_zero = (r_b[30:0] == 31'd0);

  logic        w_special;
  logic [31:0] w_spec_z;
  logic [3:0]  w_spec_flags;

  // Special-operand result, first matching rule wins
  always_comb begin
    w_special    = 1'b1;
    w_spec_z     = 32'd0;
    w_spec_flags = 4'd0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_spec_z     = 32'h7FC0_0000;
      w_spec_flags = 4'b1000;
    end else if (w_a_inf) begin
      w_spec_z = {r_sign, 8'hFF, 23'd0};
    end else if (w_b_inf) begin
      w_spec_z = {r_sign, 31'd0};
    end else if (w_b_zero) begin
      w_spec_z     = {r_sign, 8'hFF, 23'd0};
      w_spec_flags = 4'b0100;
    end else if (w_a_zero) begin
      w_spec_z = {r_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Restoring step: the remainder minus divisor always fits in 24 bits when taken
  logic        w_ge;
  logic [23:0] w_rem_sub;

  assign w_ge      = (r_rem >= {1'b0, r_bm});
  assign w_rem_sub = w_ge ? (r_rem[23:0] - r_bm) : r_rem[23:0];

  logic [26:0]       w_pn_q;
  logic [23:0]       w_pn_mant;
  logic              w_pn_g, w_pn_r, w_pn_s, w_pn_shift, w_pn_more;
  logic signed [9:0] w_pn_ze;

  // Post-normalisation: first cycle aligns the quotient, later cycles shift into the denormal range
  always_comb begin
    w_pn_q     = r_q;
    w_pn_ze    = r_ze;
    w_pn_mant  = r_mant;
    w_pn_g     = r_g;
    w_pn_r     = r_r;
    w_pn_s     = r_s;
    w_pn_shift = 1'b0;
    if (r_pn_first) begin
      if (r_q[26]) begin
        w_pn_q  = r_q;
        w_pn_ze = r_ze;
      end else begin
        w_pn_q  = {r_q[25:0], 1'b0};
        w_pn_ze = r_ze - 10'sd1;
      end
      w_pn_mant = w_pn_q[26:3];
      w_pn_g    = w_pn_q[2];
      w_pn_r    = w_pn_q[1];
      w_pn_s    = w_pn_q[0] | (r_rem != 25'd0);
    end else begin
      w_pn_mant  = {1'b0, r_mant[23:1]};
      w_pn_g     = r_mant[0];
      w_pn_r     = r_g;
      w_pn_s     = r_s | r_r;
      w_pn_ze    = r_ze + 10'sd1;
      w_pn_shift = 1'b1;
    end
  end

  // Keep shifting while below the minimum exponent and something significant remains
  assign w_pn_more = (w_pn_ze < -10'sd126) && ({w_pn_mant, w_pn_g, w_pn_r} != 26'd0);

  logic              w_rnd_up;
  logic [24:0]       w_inc;
  logic [23:0]       w_rnd_mant;
  logic signed [9:0] w_rnd_ze;

  assign w_rnd_up = r_g & (r_r | r_s | r_mant[0]);
  assign w_inc    = {1'b0, r_mant} + 25'd1;

  // Round to nearest even; a carry out of the full mantissa bumps the exponent
  always_comb begin
    w_rnd_mant = r_mant;
    w_rnd_ze   = r_ze;
    if (w_rnd_up) begin
      if (w_inc[24]) begin
        w_rnd_mant = 24'h80_0000;
        w_rnd_ze   = r_ze + 10'sd1;
      end else begin
        w_rnd_mant = w_inc[23:0];
        w_rnd_ze   = r_ze;
      end
    end else begin
      w_rnd_mant = r_mant;
      w_rnd_ze   = r_ze;
    end
  end

  logic [7:0]  w_field;
  logic [31:0] w_pack_z;
  logic        w_pack_ovf;

  assign w_field = r_ze[7:0] + 8'd127;

  // Packing: overflow to infinity, denormal/zero when the hidden bit is clear
  always_comb begin
    w_pack_z   = 32'd0;
    w_pack_ovf = 1'b0;
    if (r_ze > 10'sd127) begin
      w_pack_z   = {r_sign, 8'hFF, 23'd0};
      w_pack_ovf = 1'b1;
    end else if (!r_mant[23]) begin
      w_pack_z = {r_sign, 8'd0, r_mant[22:0]};
    end else begin
      w_pack_z = {r_sign, w_field, r_mant[22:0]};
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (in_valid) w_next = S_UNPACK; else w_next = S_IDLE;
      S_UNPACK:   w_next = S_SPECIAL;
      S_SPECIAL:  if (w_special) w_next = S_PACK; else w_next = S_NORM;
      S_NORM:     if (r_am[23] && r_bm[23]) w_next = S_DIVIDE; else w_next = S_NORM;
      S_DIVIDE:   if (r_cnt == 5'd26) w_next = S_POSTNORM; else w_next = S_DIVIDE;
      S_POSTNORM: if (w_pn_more) w_next = S_POSTNORM; else w_next = S_ROUND;
      S_ROUND:    w_next = S_PACK;
      S_PACK:     w_next = S_DONE;
      S_DONE:     if (out_ready) w_next = S_IDLE; else w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= 32'd0;  r_b <= 32'd0;  r_sign <= 1'b0;
      r_ea <= 10'sd0; r_eb <= 10'sd0; r_ze <= 10'sd0;
      r_am <= 24'd0; r_bm <= 24'd0; r_rem <= 25'd0; r_q <= 27'd0; r_cnt <= 5'd0;
      r_mant <= 24'd0; r_g <= 1'b0; r_r <= 1'b0; r_s <= 1'b0;
      r_pn_first <= 1'b0; r_special <= 1'b0;
      r_z <= 32'd0; r_flags <= 4'd0; r_out_valid <= 1'b0; r_in_ready <= 1'b1;
    end else begin
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
            r_flags <= 4'd0;
            r_special <= 1'b0;
          end
        end
        S_UNPACK: begin
          r_sign <= r_a[31] ^ r_b[31];
          r_ea   <= (w_a_exp == 8'd0) ? -10'sd126 : ($signed({2'b00, w_a_exp}) - 10'sd127);
          r_eb   <= (w_b_exp == 8'd0) ? -10'sd126 : ($signed({2'b00, w_b_exp}) - 10'sd127);
          r_am   <= {(w_a_exp != 8'd0), r_a[22:0]};
          r_bm   <= {(w_b_exp != 8'd0), r_b[22:0]};
        end
        S_SPECIAL: begin
          if (w_special) begin
            r_z       <= w_spec_z;
            r_flags   <= w_spec_flags;
            r_special <= 1'b1;
          end
        end
        S_NORM: begin
          if (!r_am[23]) begin
            r_am <= {r_am[22:0], 1'b0};
            r_ea <= r_ea - 10'sd1;
          end
          if (!r_bm[23]) begin
            r_bm <= {r_bm[22:0], 1'b0};
            r_eb <= r_eb - 10'sd1;
          end
          // Divider setup is refreshed every cycle; the exit cycle sees normalised operands
          r_rem <= {1'b0, r_am};
          r_q   <= 27'd0;
          r_cnt <= 5'd0;
          r_ze  <= r_ea - r_eb;
        end
        S_DIVIDE: begin
          r_q        <= {r_q[25:0], w_ge};
          r_rem      <= {w_rem_sub, 1'b0};
          r_cnt      <= r_cnt + 5'd1;
          r_pn_first <= 1'b1;
        end
        S_POSTNORM: begin
          r_mant     <= w_pn_mant;
          r_g        <= w_pn_g;
          r_r        <= w_pn_r;
          r_s        <= w_pn_s;
          r_ze       <= w_pn_ze;
          r_pn_first <= 1'b0;
          if (w_pn_shift) r_flags[0] <= 1'b1;
        end
        S_ROUND: begin
          r_mant <= w_rnd_mant;
          r_ze   <= w_rnd_ze;
        end
        S_PACK: begin
          if (!r_special) begin
            r_z        <= w_pack_z;
            r_flags[1] <= w_pack_ovf;
          end
        end
        S_DONE: begin
          r_z <= r_z;
        end
        default: begin
          r_z <= r_z;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign flags     = r_flags;

endmodule

// File: tb/tb_float_div.sv
// tb_float_div: scoreboard bench for float_div with a value-level reference model.
module tb_float_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic [3:0]  flags;

  float_div dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .flags(flags)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   item_active = 1'b0;
  int   hold_req = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: exact rational quotient rounded to nearest even at the target precision
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rz, output logic [3:0] rf, output int rl);
    logic s;
    logic [7:0] fx, fy;
    bit xnan, ynan, xinf, yinf, xz, yz;
    longint mx, my, num, den, n, rem;
    int ex, ey, lzx, lzy, e, ec, sh, us;
    s  = x[31] ^ y[31];
    fx = x[30:23];
    fy = y[30:23];
    xnan = (fx == 8'hFF) && (x[22:0] != 23'd0);
    ynan = (fy == 8'hFF) && (y[22:0] != 23'd0);
    xinf = (fx == 8'hFF) && (x[22:0] == 23'd0);
    yinf = (fy == 8'hFF) && (y[22:0] == 23'd0);
    xz   = (x[30:0] == 31'd0);
    yz   = (y[30:0] == 31'd0);
    rz = 32'd0; rf = 4'd0; rl = 3;
    if (xnan || ynan || (xinf && yinf) || (xz && yz)) begin
      rz = 32'h7FC0_0000; rf = 4'b1000;
    end else if (xinf) rz = {s, 8'hFF, 23'd0};
    else if (yinf) rz = {s, 31'd0};
    else if (yz) begin rz = {s, 8'hFF, 23'd0}; rf = 4'b0100; end
    else if (xz) rz = {s, 31'd0};
    else begin
      mx = longint'({(fx != 8'd0), x[22:0]});
      my = longint'({(fy != 8'd0), y[22:0]});
      ex = (fx == 8'd0) ? -126 : int'(fx) - 127;
      ey = (fy == 8'd0) ? -126 : int'(fy) - 127;
      lzx = 0; lzy = 0;
      while (mx < 64'sd8388608) begin mx = mx * 2; ex--; lzx++; end
      while (my < 64'sd8388608) begin my = my * 2; ey--; lzy++; end
      e  = ex - ey - ((mx < my) ? 1 : 0);
      us = 0;
      ec = e;
      if (e < -126) begin
        us = ((-126 - e) > 26) ? 26 : (-126 - e);
        rf[0] = 1'b1;
        ec = -126;
      end
      sh = 23 - ec + ex - ey;
      if (sh >= 0) begin num = mx << sh; den = my; end
      else if (sh >= -30) begin num = mx; den = my << (-sh); end
      else begin num = 0; den = 1; end
      n   = num / den;
      rem = num % den;
      if ((2 * rem > den) || ((2 * rem == den) && n[0])) n++;
      if (n == 64'sd16777216) begin n = 64'sd8388608; ec++; end
      if (ec > 127) begin rz = {s, 8'hFF, 23'd0}; rf[1] = 1'b1; end
      else if (n >= 64'sd8388608) rz = {s, 8'(ec + 127), n[22:0]};
      else rz = {s, 8'd0, n[22:0]};
      rl = 33 + ((lzx > lzy) ? lzx : lzy) + us;
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0: v[30:0] = 31'd0;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2: begin v[30:23] = 8'hFF; if (v[22:0] == 23'd0) v[0] = 1'b1; end
      3, 4: begin v[30:23] = 8'd0; v[22:0] = v[22:0] >> $urandom_range(0, 22); end
      5: v[30:23] = 8'($urandom_range(1, 20));
      6: v[30:23] = 8'($urandom_range(235, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    exp_t it;
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 2000) begin @(negedge clk); t++; end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    if (in_ready) begin
      a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      ref_div(x, y, it.z, it.f, it.lat);
      it.a = x; it.b = y; it.acc = cyc;
      sb.push_back(it);
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      check("in_ready_after_accept", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || item_active) && t < 3000) begin @(negedge clk); t++; end
    check("drain_timeout", 64'(sb.size()) + 64'(item_active), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each new result and checks it stays stable until taken
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!item_active) begin
          check("unexpected_out", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            item_active = 1'b1;
            check($sformatf("z a=%h b=%h", cur.a, cur.b), 64'(z), 64'(cur.z));
            check($sformatf("flags a=%h b=%h", cur.a, cur.b), 64'(flags), 64'(cur.f));
            check($sformatf("latency a=%h b=%h", cur.a, cur.b), 64'(cyc - cur.acc), 64'(cur.lat));
            check("in_ready_busy", 64'(in_ready), 64'd0);
          end
        end else begin
          check("z_hold", 64'(z), 64'(cur.z));
          check("flags_hold", 64'(flags), 64'(cur.f));
          check("in_ready_hold", 64'(in_ready), 64'd0);
        end
        if (hold_req > 0) begin
          out_ready = 1'b0;
          hold_req--;
        end else begin
          out_ready = ($urandom_range(0, 2) == 0);
        end
        if (out_ready) item_active = 1'b0;
      end else begin
        out_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_z", 64'(z), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    issue(32'h40C0_0000, 32'h4000_0000); drain();
    issue(32'h3F80_0000, 32'h4040_0000); drain();
    issue(32'h3F80_0000, 32'h0000_0000); drain();
    issue(32'h0000_0000, 32'h0000_0000); drain();
    issue(32'h7F00_0000, 32'h0080_0000); drain();
    issue(32'h0080_0000, 32'h4000_0000); drain();
    issue(32'h0000_0001, 32'h3F00_0000); drain();

    // Result held for 10 cycles while the operand inputs wander
    hold_req = 10;
    issue(32'h3F80_0000, 32'h4040_0000);
    repeat (50) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
    end
    drain();

    // Reset in the middle of the divide loop discards the operation
    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_z", 64'(z), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    issue(32'h40C0_0000, 32'h4000_0000); drain();

    for (int i = 0; i < 150; i++) begin
      issue(rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
